// File: rtl/if_pkg.sv
// -----------------------------------------------------------------------------
// if_pkg
// Shared definitions for the instruction-fetch stage:
//   - if_state_t   : fetch FSM state encoding
//   - NOP          : instruction word used for bubbles
//   - JIDX_MSB     : top bit of the j/jal jump index field
//   - OPC_MSB/LSB  : opcode field position
//   - jump_target(): j/jal target from IF/ID PC+4 and the jump index
// -----------------------------------------------------------------------------
package if_pkg;

    typedef enum logic [1:0] {
        ST_BOOT       = 2'd0,
        ST_FETCH      = 2'd1,
        ST_HOLD       = 2'd2,
        ST_REDIR_WAIT = 2'd3
    } if_state_t;

    localparam logic [31:0] NOP      = 32'h0000_0000;
    localparam int          JIDX_MSB = 25;
    localparam int          OPC_MSB  = 31;
    localparam int          OPC_LSB  = 26;

    // j/jal keep the 256 MB region of the delay-slot PC.
    function automatic logic [31:0] jump_target(input logic [31:0]       pc4,
                                                input logic [JIDX_MSB:0] jidx);
        return {pc4[31:28], jidx, 2'b00};
    endfunction

endpackage

// File: rtl/if_redirect_sel.sv
// -----------------------------------------------------------------------------
// if_redirect_sel
// Combinational redirect selection for the fetch stage.
// Ports:
//   stall          in   hazard stall; ID controls are stale while high
//   PCSrc          in   taken branch in ID
//   Jump           in   j/jal in ID
//   JumpR          in   jr/jalr in ID
//   branch_target  in   branch target from ID
//   jr_target      in   forwarded rs value
//   jump_index     in   IF/ID instruction [25:0]
//   ifid_pc4       in   IF/ID PC+4
//   redirect_valid out  a redirect is requested this cycle
//   target         out  selected redirect address (JumpR > Jump > PCSrc)
// -----------------------------------------------------------------------------
module if_redirect_sel
    import if_pkg::*;
(
    input  logic              stall,
    input  logic              PCSrc,
    input  logic              Jump,
    input  logic              JumpR,
    input  logic [31:0]       branch_target,
    input  logic [31:0]       jr_target,
    input  logic [JIDX_MSB:0] jump_index,
    input  logic [31:0]       ifid_pc4,
    output logic              redirect_valid,
    output logic [31:0]       target
);

    always_comb begin
        redirect_valid = !stall && (JumpR || Jump || PCSrc);
        target         = branch_target;
        if (JumpR) begin
            target = jr_target;
        end else if (Jump) begin
            target = jump_target(ifid_pc4, jump_index);
        end
    end

endmodule

// File: rtl/if_stage.sv
// -----------------------------------------------------------------------------
// if_stage
// Instruction-fetch stage: PC, I-cache request handshake, IF/ID register.
// Ports:
//   clk, rst_n              clock (rising edge), async active-low reset
//   stall                   freeze PC and IF/ID (hazard unit / D-cache)
//   PCSrc, branch_target    taken branch and its target from ID
//   Jump                    j/jal in ID (target built from IF/ID)
//   JumpR, jr_target        jr/jalr in ID and forwarded rs
//   IF_Flush                squash the instruction being fetched
//   ic_read, ic_addr        I-cache request and word-aligned byte address
//   ic_stall, ic_rdata      I-cache busy and returned instruction
//   pc                      current fetch PC
//   IFID_inst/pc4/valid     IF/ID pipeline register (valid=0 is a bubble)
// -----------------------------------------------------------------------------
module if_stage
    import if_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
)(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        PCSrc,
    input  logic [31:0] branch_target,
    input  logic        Jump,
    input  logic        JumpR,
    input  logic [31:0] jr_target,
    input  logic        IF_Flush,
    output logic        ic_read,
    output logic [31:0] ic_addr,
    input  logic        ic_stall,
    input  logic [31:0] ic_rdata,
    output logic [31:0] pc,
    output logic [31:0] IFID_inst,
    output logic [31:0] IFID_pc4,
    output logic        IFID_valid
);

    if_state_t   state_reg;
    logic [31:0] pc_reg;
    logic        ic_read_reg;
    logic [31:0] ifid_inst_reg;
    logic [31:0] ifid_pc4_reg;
    logic        ifid_valid_reg;
    logic [31:0] hold_inst_reg;
    logic [31:0] hold_pc4_reg;
    logic [31:0] redir_pc_reg;

    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic [31:0] pc_plus4;
    logic        flush;

    assign pc_plus4 = pc_reg + 32'd4;
    // ID controls are only meaningful when the pipeline is not stalled.
    assign flush    = IF_Flush && !stall;

    if_redirect_sel u_redirect_sel (
        .stall          (stall),
        .PCSrc          (PCSrc),
        .Jump           (Jump),
        .JumpR          (JumpR),
        .branch_target  (branch_target),
        .jr_target      (jr_target),
        .jump_index     (ifid_inst_reg[JIDX_MSB:0]),
        .ifid_pc4       (ifid_pc4_reg),
        .redirect_valid (redirect_valid),
        .target         (redirect_target)
    );

    // A bubble clears instruction and valid; IFID_pc4 is left as is since
    // nothing downstream uses it when valid=0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= ST_BOOT;
            pc_reg         <= RESET_PC;
            ic_read_reg    <= 1'b0;
            ifid_inst_reg  <= NOP;
            ifid_pc4_reg   <= 32'h0;
            ifid_valid_reg <= 1'b0;
            hold_inst_reg  <= NOP;
            hold_pc4_reg   <= 32'h0;
            redir_pc_reg   <= RESET_PC;
        end else begin
            case (state_reg)
                ST_BOOT: begin
                    state_reg   <= ST_FETCH;
                    ic_read_reg <= 1'b1;
                end

                ST_FETCH: begin
                    if (redirect_valid) begin
                        ifid_inst_reg  <= NOP;
                        ifid_valid_reg <= 1'b0;
                        if (!ic_stall) begin
                            pc_reg <= redirect_target;
                        end else begin
                            // Request in flight cannot be aborted: keep ic_addr
                            // stable and remember where to go afterwards.
                            redir_pc_reg <= redirect_target;
                            state_reg    <= ST_REDIR_WAIT;
                        end
                    end else if (stall) begin
                        if (!ic_stall) begin
                            // Data arrives while ID cannot take it: park it.
                            hold_inst_reg <= ic_rdata;
                            hold_pc4_reg  <= pc_plus4;
                            pc_reg        <= pc_plus4;
                            state_reg     <= ST_HOLD;
                            ic_read_reg   <= 1'b0;
                        end
                    end else if (!ic_stall) begin
                        pc_reg <= pc_plus4;
                        if (flush) begin
                            ifid_inst_reg  <= NOP;
                            ifid_valid_reg <= 1'b0;
                        end else begin
                            ifid_inst_reg  <= ic_rdata;
                            ifid_pc4_reg   <= pc_plus4;
                            ifid_valid_reg <= 1'b1;
                        end
                    end else begin
                        ifid_inst_reg  <= NOP;
                        ifid_valid_reg <= 1'b0;
                    end
                end

                ST_HOLD: begin
                    if (!stall) begin
                        state_reg   <= ST_FETCH;
                        ic_read_reg <= 1'b1;
                        if (redirect_valid) begin
                            pc_reg         <= redirect_target;
                            ifid_inst_reg  <= NOP;
                            ifid_valid_reg <= 1'b0;
                        end else if (flush) begin
                            ifid_inst_reg  <= NOP;
                            ifid_valid_reg <= 1'b0;
                        end else begin
                            ifid_inst_reg  <= hold_inst_reg;
                            ifid_pc4_reg   <= hold_pc4_reg;
                            ifid_valid_reg <= 1'b1;
                        end
                    end
                end

                ST_REDIR_WAIT: begin
                    if (!stall) begin
                        ifid_inst_reg  <= NOP;
                        ifid_valid_reg <= 1'b0;
                    end
                    if (!ic_stall) begin
                        // Stale data is dropped; a redirect arriving in this
                        // very cycle is the most recent and wins.
                        pc_reg    <= redirect_valid ? redirect_target : redir_pc_reg;
                        state_reg <= ST_FETCH;
                    end else if (redirect_valid) begin
                        redir_pc_reg <= redirect_target;
                    end
                end

                default: begin
                    state_reg   <= ST_BOOT;
                    ic_read_reg <= 1'b0;
                end
            endcase
        end
    end

    assign ic_read    = ic_read_reg;
    assign ic_addr    = pc_reg;
    assign pc         = pc_reg;
    assign IFID_inst  = ifid_inst_reg;
    assign IFID_pc4   = ifid_pc4_reg;
    assign IFID_valid = ifid_valid_reg;

endmodule

// File: tb/tb_if_stage.sv
// -----------------------------------------------------------------------------
// tb_if_stage
// Self-checking bench for if_stage. Each stimulus cycle pushes the expected
// post-edge outputs into a scoreboard queue; the entry is popped and compared
// on the following falling edge.
// -----------------------------------------------------------------------------
module tb_if_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        PCSrc = 1'b0;
    logic [31:0] branch_target = 32'h0;
    logic        Jump = 1'b0;
    logic        JumpR = 1'b0;
    logic [31:0] jr_target = 32'h0;
    logic        IF_Flush = 1'b0;
    logic        ic_read;
    logic [31:0] ic_addr;
    logic        ic_stall = 1'b0;
    logic [31:0] ic_rdata;
    logic [31:0] pc;
    logic [31:0] IFID_inst;
    logic [31:0] IFID_pc4;
    logic        IFID_valid;

    logic        use_special = 1'b0;
    logic [31:0] special = 32'h0;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct packed {
        logic        rd;
        logic [31:0] addr;
        logic        v;
        logic [31:0] inst;
        logic [31:0] pc4;
    } exp_t;

    exp_t  exp_q[$];
    string tag_q[$];

    // Instruction memory contents: a j-format word whose index encodes addr+0x100.
    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return {6'b000010, a[27:2] + 26'h40};
    endfunction

    function automatic logic [31:0] jtgt(input logic [31:0] pc4, input logic [31:0] inst);
        return {pc4[31:28], inst[25:0], 2'b00};
    endfunction

    function automatic exp_t ev(input logic rd, input logic [31:0] addr, input logic v,
                                input logic [31:0] inst, input logic [31:0] pc4);
        exp_t e;
        e.rd = rd; e.addr = addr; e.v = v; e.inst = inst; e.pc4 = pc4;
        return e;
    endfunction

    assign ic_rdata = use_special ? special : inst_of(ic_addr);

    always #5 clk = ~clk;

    if_stage #(.RESET_PC(32'h0000_0000)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall         (stall),
        .PCSrc         (PCSrc),
        .branch_target (branch_target),
        .Jump          (Jump),
        .JumpR         (JumpR),
        .jr_target     (jr_target),
        .IF_Flush      (IF_Flush),
        .ic_read       (ic_read),
        .ic_addr       (ic_addr),
        .ic_stall      (ic_stall),
        .ic_rdata      (ic_rdata),
        .pc            (pc),
        .IFID_inst     (IFID_inst),
        .IFID_pc4      (IFID_pc4),
        .IFID_valid    (IFID_valid)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic compare_head();
        exp_t  e;
        string t;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        chk({t, ".ic_read"}, 32'(ic_read), 32'(e.rd));
        chk({t, ".ic_addr"}, ic_addr, e.addr);
        chk({t, ".pc"}, pc, e.addr);
        chk({t, ".valid"}, 32'(IFID_valid), 32'(e.v));
        chk({t, ".inst"}, IFID_inst, e.inst);
        if (e.v) chk({t, ".pc4"}, IFID_pc4, e.pc4);
        $display("cyc %-10s addr=%08h rd=%0d v=%0d inst=%08h pc4=%08h",
                 t, ic_addr, ic_read, IFID_valid, IFID_inst, IFID_pc4);
    endtask

    // Drive one cycle of stimulus (called at a falling edge), then check.
    task automatic cyc(input string tag, input logic ics, input logic st,
                       input logic br, input logic jmp, input logic jr, input logic fl,
                       input logic [31:0] bt, input logic [31:0] jt, input exp_t e);
        ic_stall = ics; stall = st; PCSrc = br; Jump = jmp; JumpR = jr;
        IF_Flush = fl; branch_target = bt; jr_target = jt;
        exp_q.push_back(e);
        tag_q.push_back(tag);
        @(negedge clk);
        compare_head();
    endtask

    task automatic go(input string tag, input logic ics, input logic st, input exp_t e);
        cyc(tag, ics, st, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, e);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, ".ic_read"}, 32'(ic_read), 32'h0);
        chk({tag, ".pc"}, pc, 32'h0);
        chk({tag, ".valid"}, 32'(IFID_valid), 32'h0);
        chk({tag, ".inst"}, IFID_inst, 32'h0);
        chk({tag, ".pc4"}, IFID_pc4, 32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        chk_reset("reset");
        rst_n = 1'b1;
        #1;
        chk("boot.ic_read", 32'(ic_read), 32'h0);

        // Sequential fetch after BOOT
        go("boot", 0, 0, ev(1, 32'h0, 0, 32'h0, 32'h0));
        go("seq0", 0, 0, ev(1, 32'h4, 1, inst_of(32'h0), 32'h4));
        go("seq1", 0, 0, ev(1, 32'h8, 1, inst_of(32'h4), 32'h8));
        go("seq2", 0, 0, ev(1, 32'hC, 1, inst_of(32'h8), 32'hC));
        go("seq3", 0, 0, ev(1, 32'h10, 1, inst_of(32'hC), 32'h10));

        // Taken branch at pc=0x10
        cyc("br", 0, 0, 1, 0, 0, 1, 32'h40, 32'h0, ev(1, 32'h40, 0, 32'h0, 32'h0));
        go("br_tgt", 0, 0, ev(1, 32'h44, 1, inst_of(32'h40), 32'h44));

        // Cache miss of three cycles at 0x8
        cyc("jr8", 0, 0, 0, 0, 1, 1, 32'h0, 32'h8, ev(1, 32'h8, 0, 32'h0, 32'h0));
        for (int i = 0; i < 3; i++) go("miss", 1, 0, ev(1, 32'h8, 0, 32'h0, 32'h0));
        go("miss_done", 0, 0, ev(1, 32'hC, 1, inst_of(32'h8), 32'hC));

        // Redirect during a miss; a later redirect overrides the first
        cyc("jr8b", 0, 0, 0, 0, 1, 1, 32'h0, 32'h8, ev(1, 32'h8, 0, 32'h0, 32'h0));
        cyc("jr_miss", 1, 0, 0, 0, 1, 1, 32'h0, 32'h100, ev(1, 32'h8, 0, 32'h0, 32'h0));
        go("rw0", 1, 0, ev(1, 32'h8, 0, 32'h0, 32'h0));
        cyc("rw_br", 1, 0, 1, 0, 0, 1, 32'h200, 32'h0, ev(1, 32'h8, 0, 32'h0, 32'h0));
        go("rw_done", 0, 0, ev(1, 32'h200, 0, 32'h0, 32'h0));
        go("rw_tgt", 0, 0, ev(1, 32'h204, 1, inst_of(32'h200), 32'h204));

        // Pipeline stall while the cache returns 0xDEADBEEF for 0x8
        cyc("jr4", 0, 0, 0, 0, 1, 1, 32'h0, 32'h4, ev(1, 32'h4, 0, 32'h0, 32'h0));
        go("f4", 0, 0, ev(1, 32'h8, 1, inst_of(32'h4), 32'h8));
        use_special = 1'b1;
        special = 32'hDEAD_BEEF;
        go("hold_in", 0, 1, ev(0, 32'hC, 1, inst_of(32'h4), 32'h8));
        cyc("hold_ign", 0, 1, 1, 0, 0, 1, 32'h300, 32'h0, ev(0, 32'hC, 1, inst_of(32'h4), 32'h8));
        use_special = 1'b0;
        go("hold_out", 0, 0, ev(1, 32'hC, 1, 32'hDEAD_BEEF, 32'hC));
        go("after_hold", 0, 0, ev(1, 32'h10, 1, inst_of(32'hC), 32'h10));

        // j using the IF/ID jump index
        cyc("j", 0, 0, 0, 1, 0, 1, 32'h0, 32'h0,
            ev(1, jtgt(32'h10, inst_of(32'hC)), 0, 32'h0, 32'h0));
        go("j_tgt", 0, 0, ev(1, 32'h110, 1, inst_of(32'h10C), 32'h110));

        // Priority JumpR > Jump > PCSrc
        cyc("prio3", 0, 0, 1, 1, 1, 1, 32'h500, 32'h600, ev(1, 32'h600, 0, 32'h0, 32'h0));
        go("prio3_t", 0, 0, ev(1, 32'h604, 1, inst_of(32'h600), 32'h604));
        cyc("prio2", 0, 0, 1, 1, 0, 1, 32'h500, 32'h0,
            ev(1, jtgt(32'h604, inst_of(32'h600)), 0, 32'h0, 32'h0));
        go("f700", 0, 0, ev(1, 32'h704, 1, inst_of(32'h700), 32'h704));

        // stall + ic_stall freezes everything, redirect ignored while stalled
        cyc("freeze", 1, 1, 1, 0, 0, 1, 32'h900, 32'h0, ev(1, 32'h704, 1, inst_of(32'h700), 32'h704));
        go("freeze_rel", 0, 0, ev(1, 32'h708, 1, inst_of(32'h704), 32'h708));

        // Lone IF_Flush: bubble, PC still advances
        cyc("flush", 0, 0, 0, 0, 0, 1, 32'h0, 32'h0, ev(1, 32'h70C, 0, 32'h0, 32'h0));

        // PC+4 wraps modulo 2^32
        cyc("jr_wrap", 0, 0, 0, 0, 1, 1, 32'h0, 32'hFFFF_FFFC, ev(1, 32'hFFFF_FFFC, 0, 32'h0, 32'h0));
        go("wrap", 0, 0, ev(1, 32'h0, 1, inst_of(32'hFFFF_FFFC), 32'h0));

        // Reset in the middle of a miss
        go("f0", 0, 0, ev(1, 32'h4, 1, inst_of(32'h0), 32'h4));
        go("miss2", 1, 0, ev(1, 32'h4, 0, 32'h0, 32'h0));
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset("rst_mid");
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("boot2.ic_read", 32'(ic_read), 32'h0);
        go("boot2", 0, 0, ev(1, 32'h0, 0, 32'h0, 32'h0));
        go("r0", 0, 0, ev(1, 32'h4, 1, inst_of(32'h0), 32'h4));
        go("r1", 0, 0, ev(1, 32'h8, 1, inst_of(32'h4), 32'h8));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
